datamem_arbiter: RTL and testbench

- Shares the processor's single-port data memory (datamem) between two requesters: the CPU load/store port and an auxiliary port used for I/O, DMA or testbench preload.
- Sits between the processor's memory-stage signals and datamem.
- Issues at most one access per cycle and returns read data one cycle later, tagged to the requester that issued it.
- Supports a bounded bus lock so a requester can perform atomic read-modify-write sequences.

---
 rtl/datamem_arbiter_pkg.sv | 22 ++
 rtl/datamem_arbiter_if.sv | 51 +++++
 rtl/datamem_arb_port_mux.sv | 35 +++
 rtl/datamem_arbiter.sv | 143 ++++++++++++++
 tb/tb_datamem_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/datamem_arbiter_pkg.sv
// rtl/datamem_arbiter_pkg.sv - shared encodings and defaults for the datamem arbiter
package datamem_arbiter_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_ADDR_W = 10;

    typedef enum logic [1:0] {
        ARB_UNLOCKED = 2'd0,
        ARB_LOCK_CPU = 2'd1,
        ARB_LOCK_AUX = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_AUX = 1'b1
    } arb_port_e;

    function automatic arb_port_e arb_other(input arb_port_e p);
        return (p == ARB_CPU) ? ARB_AUX : ARB_CPU;
    endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// rtl/datamem_arbiter_if.sv - requester and datamem signal bundle for the arbiter
interface datamem_arbiter_if
    import datamem_arbiter_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_lock;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              aux_req;
    logic              aux_we;
    logic              aux_lock;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_ready;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        input  aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        output aux_ready, aux_rvalid, aux_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        output aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        input  aux_ready, aux_rvalid, aux_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/datamem_arb_port_mux.sv
// rtl/datamem_arb_port_mux.sv - steers the granted port's access fields onto datamem
module datamem_arb_port_mux
    import datamem_arbiter_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W
) (
    input  logic              en,
    input  arb_port_e         sel,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    always_comb begin
        mem_en = en;
        if (sel == ARB_AUX) begin
            mem_we    = en & aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
        end else begin
            mem_we    = en & cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - two-port datamem arbiter with bounded lock
// Optional: DATAMEM_ARB_ROUND_ROBIN_EN enables alternating priority under contention.
module datamem_arbiter
    import datamem_arbiter_pkg::*;
#(
    parameter int DATA_W   = ARB_DATA_W,
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int LOCK_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    datamem_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arb_port_e        prio_q, prio_d;
    logic             pend_cpu_q, pend_cpu_d;
    logic             pend_aux_q, pend_aux_d;

    logic             gnt_valid;
    arb_port_e        gnt_port;
    logic             gnt_lock;
    logic             contested;
    logic             cpu_ready;
    logic             aux_ready;
    logic             cpu_rvalid;
    logic             aux_rvalid;

    // Grant is purely combinational; reset masks every grant in the same cycle.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = ARB_CPU;
        contested = bus.cpu_req & bus.aux_req;
        if (!rst) begin
            case (state_q)
                ARB_LOCK_CPU: begin
                    gnt_valid = bus.cpu_req;
                    gnt_port  = ARB_CPU;
                end
                ARB_LOCK_AUX: begin
                    gnt_valid = bus.aux_req;
                    gnt_port  = ARB_AUX;
                end
                default: begin
                    gnt_valid = bus.cpu_req | bus.aux_req;
                    if (contested) begin
                        gnt_port = prio_q;
                    end else if (bus.aux_req) begin
                        gnt_port = ARB_AUX;
                    end
                end
            endcase
        end
    end

    assign cpu_ready = gnt_valid & (gnt_port == ARB_CPU);
    assign aux_ready = gnt_valid & (gnt_port == ARB_AUX);
    assign gnt_lock  = (gnt_port == ARB_CPU) ? bus.cpu_lock : bus.aux_lock;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        pend_cpu_d = cpu_ready & ~bus.cpu_we;
        pend_aux_d = aux_ready & ~bus.aux_we;
        case (state_q)
            ARB_LOCK_CPU, ARB_LOCK_AUX: begin
                // Timeout wins over a renewed lock request so the hold stays bounded.
                if (cnt_q == CNT_W'(LOCK_MAX)) begin
                    state_d = ARB_UNLOCKED;
                    cnt_d   = '0;
                    prio_d  = arb_other((state_q == ARB_LOCK_CPU) ? ARB_CPU : ARB_AUX);
                end else if (gnt_valid && !gnt_lock) begin
                    state_d = ARB_UNLOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (gnt_valid && contested) begin
`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
                    prio_d = arb_other(gnt_port);
`else
                    prio_d = ARB_CPU;
`endif
                end
                if (gnt_valid && gnt_lock) begin
                    state_d = (gnt_port == ARB_CPU) ? ARB_LOCK_CPU : ARB_LOCK_AUX;
                    cnt_d   = CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_UNLOCKED;
            cnt_q      <= '0;
            prio_q     <= ARB_CPU;
            pend_cpu_q <= 1'b0;
            pend_aux_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            pend_cpu_q <= pend_cpu_d;
            pend_aux_q <= pend_aux_d;
        end
    end

    datamem_arb_port_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_mux (
        .en        (gnt_valid),
        .sel       (gnt_port),
        .cpu_we    (bus.cpu_we),
        .cpu_addr  (bus.cpu_addr),
        .cpu_wdata (bus.cpu_wdata),
        .aux_we    (bus.aux_we),
        .aux_addr  (bus.aux_addr),
        .aux_wdata (bus.aux_wdata),
        .mem_en    (bus.mem_en),
        .mem_we    (bus.mem_we),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata)
    );

    // Read data is passed straight from datamem in the pulse cycle; reset squashes it.
    assign cpu_rvalid     = pend_cpu_q & ~rst;
    assign aux_rvalid     = pend_aux_q & ~rst;
    assign bus.cpu_ready  = cpu_ready;
    assign bus.aux_ready  = aux_ready;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.aux_rvalid = aux_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.aux_rdata  = aux_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - directed self-checking bench for datamem_arbiter
module tb_datamem_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] mem [0:1023];

    datamem_arbiter_if #(.DATA_W(32), .ADDR_W(10)) bus ();

    datamem_arbiter #(.DATA_W(32), .ADDR_W(10), .LOCK_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic lock,
                           input logic [9:0] addr, input logic [31:0] wdata);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_lock = lock;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    endtask

    task automatic set_aux(input logic req, input logic we, input logic lock,
                           input logic [9:0] addr, input logic [31:0] wdata);
        bus.aux_req = req; bus.aux_we = we; bus.aux_lock = lock;
        bus.aux_addr = addr; bus.aux_wdata = wdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_cpu(0, 0, 0, 0, 0);
        set_aux(0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_cpu(1, 0, 0, 10'd0, 0);
        set_aux(1, 0, 0, 10'd1, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b exp 0", bus.mem_en); end
            checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready: got %b exp 0", bus.cpu_ready); end
            checks++; if (bus.aux_ready !== 1'b0) begin errors++; $display("FAIL rst_aux_ready: got %b exp 0", bus.aux_ready); end
            checks++; if (bus.cpu_rvalid !== 1'b0 || bus.aux_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b exp 00", bus.cpu_rvalid, bus.aux_rvalid); end
            checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h exp 0", bus.cpu_rdata); end
            next_cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1 || bus.aux_ready !== 1'b0) begin errors++; $display("FAIL rst_first_grant: got cpu=%b aux=%b exp cpu=1 aux=0", bus.cpu_ready, bus.aux_ready); end
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL rst_first_mem_en: got %b exp 1", bus.mem_en); end
        next_cycle();
    endtask

    task automatic test_write_read();
        do_reset();
        set_cpu(1, 1, 0, 10'd3, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b exp 1", bus.cpu_ready); end
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd3 || bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem: got we=%b addr=%0d data=%h exp we=1 addr=3 data=deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        next_cycle();
        set_cpu(1, 0, 0, 10'd3, 0);
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_issue: got ready=%b we=%b exp ready=1 we=0", bus.cpu_ready, bus.mem_we); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b exp 0", bus.cpu_rvalid); end
        next_cycle();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got v=%b d=%h exp v=1 d=deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
        checks++; if (bus.aux_rvalid !== 1'b0) begin errors++; $display("FAIL rd_aux_quiet: got %b exp 0", bus.aux_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse_len: got %b exp 0", bus.cpu_rvalid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_cpu(1, 0, 0, 10'd3, 0);
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready: got %b exp 1", bus.cpu_ready); end
        next_cycle();
        set_cpu(0, 0, 0, 0, 0);
        set_aux(1, 1, 0, 10'd7, 32'h000055AA);
        @(negedge clk);
        checks++; if (bus.aux_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd7) begin errors++; $display("FAIL b2b_aux_wr: got ready=%b we=%b addr=%0d exp 1 1 7", bus.aux_ready, bus.mem_we, bus.mem_addr); end
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_cpu_rdata: got v=%b d=%h exp v=1 d=deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [3:0] exp_aux;
        logic       prev_aux;
`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
        exp_aux = 4'b1010;
`else
        exp_aux = 4'b0000;
`endif
        do_reset();
        set_cpu(1, 0, 0, 10'd3, 0);
        set_aux(1, 0, 0, 10'd2, 0);
        prev_aux = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.aux_ready !== exp_aux[i] || bus.cpu_ready !== ~exp_aux[i]) begin errors++; $display("FAIL contend_grant%0d: got cpu=%b aux=%b exp aux=%b", i, bus.cpu_ready, bus.aux_ready, exp_aux[i]); end
            if (i > 0) begin
                checks++; if (bus.aux_rvalid !== prev_aux || bus.cpu_rvalid !== ~prev_aux) begin errors++; $display("FAIL contend_rvalid%0d: got cpu=%b aux=%b exp aux=%b", i, bus.cpu_rvalid, bus.aux_rvalid, prev_aux); end
            end
            prev_aux = exp_aux[i];
            next_cycle();
        end
    endtask

    task automatic test_lock();
        do_reset();
        set_aux(1, 0, 1, 10'd2, 0);
        @(negedge clk);
        checks++; if (bus.aux_ready !== 1'b1 || bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL lock_acquire: got aux=%b cpu=%b exp aux=1 cpu=0", bus.aux_ready, bus.cpu_ready); end
        next_cycle();
        set_aux(0, 0, 0, 0, 0);
        set_cpu(1, 0, 0, 10'd5, 0);
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL lock_idle_block: got cpu=%b en=%b exp 0 0", bus.cpu_ready, bus.mem_en); end
        checks++; if (bus.aux_rvalid !== 1'b1 || bus.aux_rdata !== 32'hCAFE0002) begin errors++; $display("FAIL lock_aux_rdata: got v=%b d=%h exp v=1 d=cafe0002", bus.aux_rvalid, bus.aux_rdata); end
        next_cycle();
        set_aux(1, 1, 0, 10'd2, 32'h12345678);
        @(negedge clk);
        checks++; if (bus.aux_ready !== 1'b1 || bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL lock_release_wr: got aux=%b cpu=%b exp aux=1 cpu=0", bus.aux_ready, bus.cpu_ready); end
        next_cycle();
        set_aux(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL lock_cpu_after: got %b exp 1", bus.cpu_ready); end
        next_cycle();
    endtask

    task automatic test_lock_timeout();
        do_reset();
        set_cpu(1, 0, 1, 10'd3, 0);
        set_aux(1, 0, 0, 10'd2, 0);
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL to_acquire: got %b exp 1", bus.cpu_ready); end
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (bus.cpu_ready !== 1'b1 || bus.aux_ready !== 1'b0) begin errors++; $display("FAIL to_held%0d: got cpu=%b aux=%b exp cpu=1 aux=0", i, bus.cpu_ready, bus.aux_ready); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (bus.aux_ready !== 1'b1 || bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL to_forced_release: got aux=%b cpu=%b exp aux=1 cpu=0", bus.aux_ready, bus.cpu_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1 || bus.aux_ready !== 1'b0) begin errors++; $display("FAIL to_prio_back: got cpu=%b aux=%b exp cpu=1 aux=0", bus.cpu_ready, bus.aux_ready); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        set_cpu(1, 0, 1, 10'd3, 0);
        @(negedge clk);
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_ready: got %b exp 1", bus.cpu_ready); end
        next_cycle();
        rst = 1'b1;
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL mid_rd_cancel: got v=%b d=%h exp v=0 d=0", bus.cpu_rvalid, bus.cpu_rdata); end
        next_cycle();
        rst = 1'b0;
        set_aux(1, 0, 0, 10'd2, 0);
        @(negedge clk);
        checks++; if (bus.aux_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_unlocked: got %b exp 1", bus.aux_ready); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rd_no_late: got %b exp 0", bus.cpu_rvalid); end
        next_cycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[2] = 32'hCAFE0002;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_contention();
        test_lock();
        test_lock_timeout();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
